// File: rtl/tracker_axis_scaler.sv
// rtl/tracker_axis_scaler.sv - ASCII angle commands to per-axis servo positions via a sequential divider
module tracker_axis_scaler #(
    parameter int                        N_AXES      = 2,
    parameter int                        POS_W       = 8,
    parameter int                        DEG_W       = 10,
    parameter logic [N_AXES*DEG_W-1:0]   IN_MAX_LIST = {10'd180, 10'd270},
    parameter logic [POS_W-1:0]          PARK_POS    = 8'd128,
    localparam int                       AX_W        = (N_AXES > 1) ? $clog2(N_AXES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AX_W-1:0]           cmd_axis,
    input  logic [23:0]               cmd_ascii,
    input  logic                      park,
    output logic [N_AXES*POS_W-1:0]   pos_out,
    output logic                      upd_valid,
    output logic [AX_W-1:0]           upd_axis,
    output logic                      cmd_err
);

    localparam int              NUM_W   = DEG_W + POS_W;
    localparam int              CNT_W   = $clog2(NUM_W + 1);
    localparam logic [POS_W-1:0] POS_MAX = {POS_W{1'b1}};

    typedef enum logic [1:0] {IDLE, CONV, DIV, WRITE} state_t;

    state_t              state_q, state_d;
    logic [AX_W-1:0]     ax_q;
    logic [23:0]         ascii_q;
    logic [DEG_W-1:0]    divisor_q;
    logic [DEG_W-1:0]    rem_q;
    logic [NUM_W-1:0]    dvd_q;
    logic [POS_W-1:0]    quot_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                clamp_q;

    logic [POS_W-1:0]    target_q [N_AXES];
    logic [POS_W-1:0]    target_d [N_AXES];
    logic [POS_W-1:0]    pos_q    [N_AXES];
    logic [DEG_W-1:0]    in_max   [N_AXES];

    logic [DEG_W-1:0]    sel_max;
    logic                ax_ok;
    logic                digits_ok;
    logic [DEG_W-1:0]    deg;
    logic [NUM_W-1:0]    num;
    logic [DEG_W:0]      shifted;
    logic                q_bit;
    logic [DEG_W-1:0]    rem_next;

    if (N_AXES < 1) begin : g_bad_n_axes
        $error("N_AXES must be at least 1");
    end

    for (genvar gi = 0; gi < N_AXES; gi++) begin : g_axis
        assign in_max[gi]                   = IN_MAX_LIST[gi*DEG_W +: DEG_W];
        assign pos_out[gi*POS_W +: POS_W]   = pos_q[gi];
        if (IN_MAX_LIST[gi*DEG_W +: DEG_W] == '0) begin : g_bad_in_max
            $error("IN_MAX of every axis must be nonzero");
        end
    end

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // Axis lookup by loop so an out-of-range index never addresses the array
    always_comb begin
        sel_max = '0;
        ax_ok   = 1'b0;
        for (int i = 0; i < N_AXES; i++) begin
            if (ax_q == AX_W'(i)) begin
                sel_max = in_max[i];
                ax_ok   = 1'b1;
            end
        end
    end

    always_comb begin
        digits_ok = is_digit(ascii_q[23:16]) && is_digit(ascii_q[15:8]) && is_digit(ascii_q[7:0]);
        // Low nibble of a valid ASCII digit is its value
        deg = DEG_W'(32'(ascii_q[19:16]) * 100 + 32'(ascii_q[11:8]) * 10 + 32'(ascii_q[3:0]));
        num = NUM_W'(deg) * NUM_W'(POS_MAX);
    end

    always_comb begin
        shifted  = {rem_q, dvd_q[NUM_W-1]};
        q_bit    = (shifted >= {1'b0, divisor_q});
        rem_next = q_bit ? DEG_W'(shifted - {1'b0, divisor_q}) : DEG_W'(shifted);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = CONV;
            CONV:    state_d = (digits_ok && ax_ok) ? DIV : IDLE;
            DIV:     if (cnt_q == CNT_W'(NUM_W - 1)) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);

    always_comb begin
        for (int i = 0; i < N_AXES; i++) begin
            target_d[i] = target_q[i];
            if ((state_q == WRITE) && (ax_q == AX_W'(i))) begin
                target_d[i] = clamp_q ? POS_MAX : quot_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ax_q      <= '0;
            ascii_q   <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            clamp_q   <= 1'b0;
            upd_valid <= 1'b0;
            upd_axis  <= '0;
            cmd_err   <= 1'b0;
            for (int i = 0; i < N_AXES; i++) begin
                target_q[i] <= PARK_POS;
                pos_q[i]    <= PARK_POS;
            end
        end else begin
            state_q   <= state_d;
            upd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        ax_q    <= cmd_axis;
                        ascii_q <= cmd_ascii;
                    end
                end
                CONV: begin
                    if (!(digits_ok && ax_ok)) cmd_err <= 1'b1;
                    divisor_q <= sel_max;
                    clamp_q   <= (deg >= sel_max);
                    dvd_q     <= num;
                    rem_q     <= '0;
                    quot_q    <= '0;
                    cnt_q     <= '0;
                end
                DIV: begin
                    // Quotient always fits POS_W bits, so only the low bits are kept
                    rem_q  <= rem_next;
                    dvd_q  <= {dvd_q[NUM_W-2:0], 1'b0};
                    quot_q <= {quot_q[POS_W-2:0], q_bit};
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                WRITE: begin
                    upd_valid <= 1'b1;
                    upd_axis  <= ax_q;
                end
                default: ;
            endcase
            for (int i = 0; i < N_AXES; i++) begin
                target_q[i] <= target_d[i];
                pos_q[i]    <= park ? PARK_POS : target_d[i];
            end
        end
    end

endmodule

// File: tb/tb_tracker_axis_scaler.sv
// tb/tb_tracker_axis_scaler.sv - scoreboard bench for tracker_axis_scaler
module tb_tracker_axis_scaler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [0:0]  cmd_axis = '0;
    logic [23:0] cmd_ascii = '0;
    logic        park = 1'b0;
    logic        cmd_ready, upd_valid, cmd_err;
    logic [0:0]  upd_axis;
    logic [15:0] pos_out;

    logic        cmd_valid3 = 1'b0;
    logic [1:0]  cmd_axis3 = '0;
    logic [23:0] cmd_ascii3 = '0;
    logic        park3 = 1'b0;
    logic        cmd_ready3, upd_valid3, cmd_err3;
    logic [1:0]  upd_axis3;
    logic [23:0] pos_out3;

    tracker_axis_scaler u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_axis(cmd_axis), .cmd_ascii(cmd_ascii), .park(park), .pos_out(pos_out),
        .upd_valid(upd_valid), .upd_axis(upd_axis), .cmd_err(cmd_err)
    );

    tracker_axis_scaler #(.N_AXES(3), .IN_MAX_LIST({10'd90, 10'd180, 10'd270})) u_dut3 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_axis(cmd_axis3), .cmd_ascii(cmd_ascii3), .park(park3), .pos_out(pos_out3),
        .upd_valid(upd_valid3), .upd_axis(upd_axis3), .cmd_err(cmd_err3)
    );

    always #10 clk = ~clk;

    typedef struct {int ax; int val; int hs;} upd_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   upd_seen = 0;
    logic rst_s = 1'b1;
    logic park_s = 1'b0;
    int   tgt [2] = '{128, 128};
    upd_t upd_q [$];
    int   err_q [$];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rst_s  <= reset;
        park_s <= park;
    end

    function automatic bit model(input int ax, input logic [23:0] a, output int val);
        logic [7:0] b;
        int d = 0;
        int lim;
        val = 0;
        for (int i = 0; i < 3; i++) begin
            b = a[8*(2-i) +: 8];
            if (b < 8'h30 || b > 8'h39) return 1'b0;
            d = d * 10 + (int'(b) - 48);
        end
        if (ax >= 2) return 1'b0;
        lim = (ax == 0) ? 270 : 180;
        val = (d >= lim) ? 255 : (d * 255) / lim;
        return 1'b1;
    endfunction

    always @(negedge clk) begin : monitor
        upd_t        e;
        int          eh;
        logic [15:0] exp_pos;
        if (rst_s) begin
            upd_q.delete();
            err_q.delete();
            tgt[0] = 128;
            tgt[1] = 128;
        end else begin
            if (upd_valid) begin
                upd_seen++;
                checks++;
                if (upd_q.size() == 0) begin
                    errors++;
                    $display("FAIL upd_unexpected: got upd on axis %0d, required none", upd_axis);
                end else begin
                    e = upd_q.pop_front();
                    checks++;
                    if (int'(upd_axis) != e.ax) begin
                        errors++;
                        $display("FAIL upd_axis: got %0d, required %0d", upd_axis, e.ax);
                    end
                    checks++;
                    if (cyc - e.hs != 20) begin
                        errors++;
                        $display("FAIL upd_latency: got %0d, required 20", cyc - e.hs);
                    end
                    tgt[e.ax] = e.val;
                end
            end
            if (cmd_err) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL err_unexpected: got cmd_err, required none");
                end else begin
                    eh = err_q.pop_front();
                    checks++;
                    if (cyc - eh != 1) begin
                        errors++;
                        $display("FAIL err_latency: got %0d, required 1", cyc - eh);
                    end
                end
            end
        end
        exp_pos = (rst_s || park_s) ? 16'h8080 : {8'(tgt[1]), 8'(tgt[0])};
        checks++;
        if (pos_out !== exp_pos) begin
            errors++;
            $display("FAIL pos_out: got %h, required %h at cycle %0d", pos_out, exp_pos, cyc);
        end
    end

    task automatic send(input logic [0:0] ax, input logic [23:0] a, input bit hold,
                        output int hs, output int wait_n);
        int  v;
        upd_t e;
        cmd_axis  = ax;
        cmd_ascii = a;
        cmd_valid = 1'b1;
        wait_n    = 0;
        hs        = -1;
        while (!cmd_ready && wait_n < 60) begin
            @(negedge clk);
            wait_n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL send_timeout: cmd_ready=%b, required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        hs = cyc;
        if (model(int'(ax), a, v)) begin
            e.ax = int'(ax); e.val = v; e.hs = hs;
            upd_q.push_back(e);
        end else begin
            err_q.push_back(hs);
        end
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", cmd_ready); end
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL rst_upd: got %b, required 0", upd_valid); end
        checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, required 0", cmd_err); end
        checks++; if (upd_axis !== 1'b0) begin errors++; $display("FAIL rst_upd_axis: got %0d, required 0", upd_axis); end
        checks++; if (pos_out !== 16'h8080) begin errors++; $display("FAIL rst_pos: got %h, required 8080", pos_out); end
        checks++; if (pos_out3 !== 24'h808080) begin errors++; $display("FAIL rst_pos3: got %h, required 808080", pos_out3); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_convert();
        int h, n;
        send(1'b0, "135", 1'b0, h, n);
        send(1'b1, "045", 1'b0, h, n);
        send(1'b1, "180", 1'b0, h, n);
        send(1'b1, "300", 1'b0, h, n);
        repeat (22) @(negedge clk);
        checks++;
        if (pos_out !== {8'd255, 8'd127}) begin
            errors++;
            $display("FAIL convert_pos: got %h, required ff7f", pos_out);
        end
    endtask

    task automatic test_errors();
        int h, n;
        send(1'b0, "27A", 1'b0, h, n);
        send(1'b0, "/00", 1'b0, h, n);
        send(1'b1, "9:9", 1'b0, h, n);
        repeat (4) @(negedge clk);
        checks++;
        if (pos_out !== {8'd255, 8'd127}) begin
            errors++;
            $display("FAIL err_pos_kept: got %h, required ff7f", pos_out);
        end
    endtask

    task automatic test_bad_axis();
        int hs3, n_upd = 0, n_err = 0, w = 0;
        cmd_axis3  = 2'd3;
        cmd_ascii3 = "045";
        cmd_valid3 = 1'b1;
        @(posedge clk); #1;
        cmd_valid3 = 1'b0;
        @(negedge clk);
        checks++; if (cmd_err3 !== 1'b0) begin errors++; $display("FAIL ax3_err_early: got %b, required 0", cmd_err3); end
        @(negedge clk);
        checks++; if (cmd_err3 !== 1'b1) begin errors++; $display("FAIL ax3_err: got %b, required 1", cmd_err3); end
        repeat (25) begin
            @(negedge clk);
            if (upd_valid3) n_upd++;
            if (cmd_err3) n_err++;
        end
        checks++; if (n_upd != 0) begin errors++; $display("FAIL ax3_no_upd: got %0d, required 0", n_upd); end
        checks++; if (n_err != 0) begin errors++; $display("FAIL ax3_err_pulse: got %0d extra, required 0", n_err); end
        checks++; if (pos_out3 !== 24'h808080) begin errors++; $display("FAIL ax3_pos: got %h, required 808080", pos_out3); end
        cmd_axis3  = 2'd2;
        cmd_ascii3 = "045";
        cmd_valid3 = 1'b1;
        @(posedge clk); #1;
        hs3 = cyc;
        cmd_valid3 = 1'b0;
        while (!upd_valid3 && w < 40) begin @(negedge clk); w++; end
        checks++; if (upd_valid3 !== 1'b1) begin errors++; $display("FAIL ax3_upd_timeout: got %b, required 1", upd_valid3); end
        checks++; if (cyc - hs3 != 20) begin errors++; $display("FAIL ax3_latency: got %0d, required 20", cyc - hs3); end
        checks++; if (upd_axis3 !== 2'd2) begin errors++; $display("FAIL ax3_upd_axis: got %0d, required 2", upd_axis3); end
        checks++; if (pos_out3 !== 24'h7f8080) begin errors++; $display("FAIL ax3_pos2: got %h, required 7f8080", pos_out3); end
    endtask

    task automatic test_park();
        int h, n;
        @(negedge clk);
        park = 1'b1;
        send(1'b0, "270", 1'b0, h, n);
        repeat (22) @(negedge clk);
        checks++;
        if (pos_out !== 16'h8080) begin
            errors++;
            $display("FAIL park_pos: got %h, required 8080", pos_out);
        end
        park = 1'b0;
        @(negedge clk);
        checks++;
        if (pos_out !== {8'd255, 8'd255}) begin
            errors++;
            $display("FAIL unpark_pos: got %h, required ffff", pos_out);
        end
    endtask

    task automatic test_back_to_back();
        int h0, h1, h2, n0, n1, n2;
        send(1'b0, "090", 1'b1, h0, n0);
        send(1'b1, "090", 1'b1, h1, n1);
        send(1'b0, "200", 1'b1, h2, n2);
        cmd_valid = 1'b0;
        checks++; if (h1 - h0 != 21) begin errors++; $display("FAIL b2b_period1: got %0d, required 21", h1 - h0); end
        checks++; if (h2 - h1 != 21) begin errors++; $display("FAIL b2b_period2: got %0d, required 21", h2 - h1); end
        checks++; if (n1 != 21) begin errors++; $display("FAIL b2b_ready_wait1: got %0d, required 21", n1); end
        checks++; if (n2 != 21) begin errors++; $display("FAIL b2b_ready_wait2: got %0d, required 21", n2); end
        repeat (22) @(negedge clk);
        checks++;
        if (pos_out !== {8'd127, 8'd188}) begin
            errors++;
            $display("FAIL b2b_pos: got %h, required 7fbc", pos_out);
        end
    endtask

    task automatic test_reset_mid_div();
        int h, n, base;
        send(1'b1, "100", 1'b0, h, n);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        base = upd_seen;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_div_ready: got %b, required 1", cmd_ready);
        end
        repeat (25) @(negedge clk);
        checks++; if (upd_seen != base) begin errors++; $display("FAIL rst_div_no_upd: got %0d, required 0", upd_seen - base); end
        checks++; if (pos_out !== 16'h8080) begin errors++; $display("FAIL rst_div_pos: got %h, required 8080", pos_out); end
    endtask

    task automatic test_drain();
        checks++; if (upd_q.size() != 0) begin errors++; $display("FAIL drain_upd: got %0d pending, required 0", upd_q.size()); end
        checks++; if (err_q.size() != 0) begin errors++; $display("FAIL drain_err: got %0d pending, required 0", err_q.size()); end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_errors();
        test_bad_axis();
        test_park();
        test_back_to_back();
        test_reset_mid_div();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
